// File: rtl/conv_patch_generator.sv
// Purpose: 3x3 sliding-window patch generator over a raster pixel stream; `define CONV_PATCH_LAST_EN adds patch_last.
// Latency: patch_valid rises one cycle after the pixel that completes a window is accepted.
// Backpressure: pix_ready drops whenever a held patch is not being taken, stalling every pixel.
module conv_patch_generator #(
    parameter int WIDTH = 32,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    localparam int SIZE = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [WIDTH-1:0]           pix_data,
    input  logic                       pix_sof,
    output logic                       patch_valid,
    input  logic                       patch_ready,
    output logic [SIZE-1:0][WIDTH-1:0] patch
`ifdef CONV_PATCH_LAST_EN
    ,
    output logic                       patch_last
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {FILL, STREAM} state_t;

    state_t                      state, state_nxt;
    logic [CW-1:0]               col, col_nxt;
    logic [RW-1:0]               row, row_nxt;
    logic [CW-1:0]               ec;
    logic                        accept;
    logic                        load;
    logic                        last_nxt;
    logic [WIDTH-1:0]            lb0 [IMG_W];
    logic [WIDTH-1:0]            lb1 [IMG_W];
    logic [2:0][2:0][WIDTH-1:0]  win, win_nxt;
    logic [SIZE-1:0][WIDTH-1:0]  patch_nxt;

    assign pix_ready = !patch_valid || patch_ready;
    assign accept    = pix_valid && pix_ready;
    // A start-of-frame pixel is always column 0, whatever the counters say.
    assign ec        = pix_sof ? '0 : col;

    // Position tracking, FILL/STREAM phase and the decision to emit a patch.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        load      = 1'b0;
        last_nxt  = 1'b0;
        if (accept) begin
            if (pix_sof) begin
                col_nxt   = CW'(1);
                row_nxt   = '0;
                state_nxt = FILL;
            end else begin
                if (col == CW'(IMG_W - 1)) begin
                    col_nxt = '0;
                    if (row == RW'(IMG_H - 1)) begin
                        row_nxt   = '0;
                        state_nxt = FILL;
                    end else begin
                        row_nxt = row + RW'(1);
                        if (row == RW'(1)) begin
                            state_nxt = STREAM;
                        end
                    end
                end else begin
                    col_nxt = col + CW'(1);
                end
                // STREAM means the current row is >= 2; column must also be >= 2.
                load     = (state == STREAM) && (col >= CW'(2));
                last_nxt = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
            end
        end
    end

    // Window after this pixel: shift left, new right column from line buffers and input.
    always_comb begin
        win_nxt = win;
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win[r][1];
            win_nxt[r][1] = win[r][2];
        end
        win_nxt[0][2] = lb1[ec];
        win_nxt[1][2] = lb0[ec];
        win_nxt[2][2] = pix_data;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                patch_nxt[r*3+c] = win_nxt[r][c];
            end
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Position counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    // Line buffers (rows r-1 and r-2) and the 3x3 window advance on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb0[i] <= '0;
                lb1[i] <= '0;
            end
            win <= '0;
        end else if (accept) begin
            lb1[ec] <= lb0[ec];
            lb0[ec] <= pix_data;
            win     <= win_nxt;
        end
    end

    // Output register: load a new patch, otherwise hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            patch       <= '0;
            patch_valid <= 1'b0;
        end else if (load) begin
            patch       <= patch_nxt;
            patch_valid <= 1'b1;
        end else if (patch_ready) begin
            patch_valid <= 1'b0;
        end
    end

`ifdef CONV_PATCH_LAST_EN
    // End-of-frame flag travels with the patch it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            patch_last <= 1'b0;
        end else if (load) begin
            patch_last <= last_nxt;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_nxt;
`endif

endmodule

// File: tb/tb_conv_patch_generator.sv
module tb_conv_patch_generator;

    localparam int W  = 32;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int N  = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             pix_valid = 1'b0;
    logic             pix_sof = 1'b0;
    logic             patch_ready = 1'b1;
    logic [W-1:0]     pix_data = '0;
    logic             pix_ready;
    logic             patch_valid;
    logic [N-1:0][W-1:0] patch;
`ifdef CONV_PATCH_LAST_EN
    logic             patch_last;
`endif

    conv_patch_generator #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_sof     (pix_sof),
        .patch_valid (patch_valid),
        .patch_ready (patch_ready),
        .patch       (patch)
`ifdef CONV_PATCH_LAST_EN
        ,
        .patch_last  (patch_last)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int got   = 0;
    int g0;
    bit rnd_mode = 1'b0;

    // Reference model: frame image indexed by (row, col) plus expected patch queue.
    logic [N*W-1:0] exp_q [$];
    bit             last_q [$];
    logic [W-1:0]   img [IH][IW];
    int             mr = 0;
    int             mc = 0;
    logic [N*W-1:0] mon_e;
    bit             mon_l;
    logic [N*W-1:0] first;

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe handshakes between edges; the model tracks position from accepted pixels.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_q.delete();
            mr = 0;
            mc = 0;
        end else begin
            if (patch_valid && patch_ready) begin
                got++;
                if (exp_q.size() == 0) begin
                    chk("spurious_patch", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_l = last_q.pop_front();
                    chk("patch_data", patch, mon_e);
`ifdef CONV_PATCH_LAST_EN
                    chk("patch_last", patch_last, mon_l);
`endif
                end
            end
            if (pix_valid && pix_ready) begin
                if (pix_sof) begin
                    mr = 0;
                    mc = 0;
                end
                img[mr][mc] = pix_data;
                if (mr >= 2 && mc >= 2) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            mon_e[(i*3+j)*W +: W] = img[mr-2+i][mc-2+j];
                    exp_q.push_back(mon_e);
                    last_q.push_back(mr == IH-1 && mc == IW-1);
                end
                mc++;
                if (mc == IW) begin
                    mc = 0;
                    mr++;
                    if (mr == IH) mr = 0;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic sof);
        bit acc;
        acc = 1'b0;
        if (rnd_mode) begin
            while ($urandom_range(0, 3) == 0) begin
                pix_valid   = 1'b0;
                pix_sof     = 1'b0;
                patch_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        for (int n = 0; n < 200 && !acc; n++) begin
            if (rnd_mode) patch_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = pix_ready;
            @(posedge clk); #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
        pix_sof = 1'b0;
    endtask

    task automatic send_frame(input bit sof0, input bit rnd);
        for (int k = 0; k < IW*IH; k++)
            send(rnd ? W'($urandom) : W'(IW*(k/IW) + k%IW + 1), sof0 && k == 0);
    endtask

    task automatic drain();
        pix_valid   = 1'b0;
        pix_sof     = 1'b0;
        patch_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                first[(i*3+j)*W +: W] = W'(IW*i + j + 1);

        // Reset values
        #2;
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_patch_valid", patch_valid, 0);
        chk("rst_patch", patch, 0);
`ifdef CONV_PATCH_LAST_EN
        chk("rst_patch_last", patch_last, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stream frame with latency check
        g0 = got;
        for (int k = 0; k < 10; k++) send(W'(k+1), k == 0);
        chk("pre_latency_valid", patch_valid, 0);
        send(W'(11), 1'b0);
        chk("latency_valid", patch_valid, 1);
        chk("first_patch", patch, first);
        for (int k = 11; k < 16; k++) send(W'(k+1), 1'b0);
        drain();
        chk("stream_count", got - g0, 4);
        chk("stream_queue", exp_q.size(), 0);

        // Backpressure after first patch
        g0 = got;
        for (int k = 0; k < 11; k++) send(W'(k+1), k == 0);
        patch_ready = 1'b0;
        pix_data    = W'(12);
        pix_valid   = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_pix_ready", pix_ready, 0);
            chk("bp_patch_hold", patch, first);
            @(posedge clk); #1;
        end
        patch_ready = 1'b1;
        for (int k = 11; k < 16; k++) send(W'(k+1), 1'b0);
        drain();
        chk("bp_count", got - g0, 4);
        chk("bp_queue", exp_q.size(), 0);

        // Back-to-back frames
        g0 = got;
        send_frame(1'b1, 1'b0);
        send_frame(1'b1, 1'b0);
        drain();
        chk("b2b_count", got - g0, 8);

        // SOF resync mid-frame
        g0 = got;
        for (int k = 0; k < 6; k++) send(W'(100 + k), k == 0);
        send_frame(1'b1, 1'b0);
        drain();
        chk("sof_count", got - g0, 4);
        chk("sof_queue", exp_q.size(), 0);

        // Reset mid-frame, next frame without SOF
        for (int k = 0; k < 10; k++) send(W'(k+1), k == 0);
        pix_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_pix_ready", pix_ready, 1);
        chk("mid_rst_patch_valid", patch_valid, 0);
        chk("mid_rst_patch", patch, 0);
`ifdef CONV_PATCH_LAST_EN
        chk("mid_rst_patch_last", patch_last, 0);
`endif
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        g0 = got;
        send_frame(1'b0, 1'b0);
        drain();
        chk("post_rst_count", got - g0, 4);

        // Random data, random gaps and random backpressure
        g0 = got;
        rnd_mode = 1'b1;
        repeat (3) send_frame(1'b1, 1'b1);
        rnd_mode = 1'b0;
        drain();
        chk("rnd_count", got - g0, 12);
        chk("rnd_queue", exp_q.size(), 0);

`ifdef CONV_PATCH_LAST_EN
        // Final patch flag holds under backpressure
        for (int k = 0; k < 16; k++) send(W'(k+1), k == 0);
        patch_ready = 1'b0;
        pix_valid   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("last_hold", patch_last, 1);
            chk("last_hold_valid", patch_valid, 1);
            @(posedge clk); #1;
        end
        drain();
        chk("last_queue", exp_q.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
